// File: rtl/snake_body_decoder.sv
// Walks a head-plus-directions snake chain and streams one (x, y) tile per segment.
// Also records the computed tail position on successful completion.
module snake_body_decoder #(
    parameter int MAX_SNAKE_LENGTH = 15,
    parameter int LENGTH_BITS      = 4,
    parameter int MAP_WIDTH        = 64,
    parameter int WIDTH_BITS       = 6,
    parameter int MAP_HEIGHT       = 48,
    parameter int HEIGHT_BITS      = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [WIDTH_BITS-1:0]             head_x,
    input  logic [HEIGHT_BITS-1:0]            head_y,
    input  logic [LENGTH_BITS-1:0]            length,
    input  logic [3*(MAX_SNAKE_LENGTH-1)-1:0] segments,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH_BITS-1:0]             out_x,
    output logic [HEIGHT_BITS-1:0]            out_y,
    output logic [LENGTH_BITS-1:0]            out_idx,
    output logic                              out_last,
    output logic                              done,
    output logic                              error,
    output logic [WIDTH_BITS-1:0]             tail_x,
    output logic [HEIGHT_BITS-1:0]            tail_y
);

    localparam int SEG_BITS = 3 * (MAX_SNAKE_LENGTH - 1);
    localparam logic [WIDTH_BITS-1:0]  X_MAX = WIDTH_BITS'(MAP_WIDTH - 1);
    localparam logic [HEIGHT_BITS-1:0] Y_MAX = HEIGHT_BITS'(MAP_HEIGHT - 1);
    localparam logic [LENGTH_BITS-1:0] LEN_MAX = LENGTH_BITS'(MAX_SNAKE_LENGTH);

    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH_BITS-1:0]    x_q, x_d;
    logic [HEIGHT_BITS-1:0]   y_q, y_d;
    logic [LENGTH_BITS-1:0]   idx_q, idx_d;
    logic [LENGTH_BITS-1:0]   len_q, len_d;
    logic [SEG_BITS-1:0]      seg_q, seg_d;
    logic [WIDTH_BITS-1:0]    tail_x_q, tail_x_d;
    logic [HEIGHT_BITS-1:0]   tail_y_q, tail_y_d;

    logic [SEG_BITS-1:0]      seg_shifted;
    logic [2:0]               dir;
    logic                     is_last;
    logic [31:0]              length_ext;

    assign seg_shifted = seg_q >> (3 * int'(idx_q));
    assign dir         = seg_shifted[2:0];
    assign is_last     = (idx_q == len_q - LENGTH_BITS'(1));
    assign length_ext  = 32'(length);

    // NOTE: every variable assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        idx_d    = idx_q;
        len_d    = len_q;
        seg_d    = seg_q;
        tail_x_d = tail_x_q;
        tail_y_d = tail_y_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d   = head_x;
                    y_d   = head_y;
                    idx_d = '0;
                    seg_d = segments;
                    len_d = (length_ext > 32'(MAX_SNAKE_LENGTH)) ? LEN_MAX : length;
                    state_d = (length == '0) ? DONE : EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (is_last) begin
                        tail_x_d = x_q;
                        tail_y_d = y_q;
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q + LENGTH_BITS'(1);
                        // Wrap explicitly so a non-power-of-two map never sees an out-of-range row.
                        unique case (dir)
                            DIR_UP:    y_d = (y_q == '0)    ? Y_MAX : y_q - HEIGHT_BITS'(1);
                            DIR_DOWN:  y_d = (y_q == Y_MAX) ? '0    : y_q + HEIGHT_BITS'(1);
                            DIR_RIGHT: x_d = (x_q == X_MAX) ? '0    : x_q + WIDTH_BITS'(1);
                            DIR_LEFT:  x_d = (x_q == '0)    ? X_MAX : x_q - WIDTH_BITS'(1);
                            default: begin
                                idx_d   = idx_q;
                                state_d = ERR;
                            end
                        endcase
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            seg_q    <= '0;
            tail_x_q <= '0;
            tail_y_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            seg_q    <= seg_d;
            tail_x_q <= tail_x_d;
            tail_y_q <= tail_y_d;
        end
    end

    assign busy      = (state_q == EMIT);
    assign out_valid = (state_q == EMIT);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_idx   = idx_q;
    assign out_last  = (state_q == EMIT) && is_last;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
    assign tail_x    = tail_x_q;
    assign tail_y    = tail_y_q;

endmodule

// File: tb/tb_snake_body_decoder.sv
// Directed bench for snake_body_decoder: emission order, wrap-around, stalls,
// zero length, ignored restarts, illegal directions and mid-run reset.
module tb_snake_body_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  head_x = '0;
    logic [5:0]  head_y = '0;
    logic [3:0]  length = '0;
    logic [41:0] segments = '0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_x;
    logic [5:0]  out_y;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        done;
    logic        error;
    logic [5:0]  tail_x;
    logic [5:0]  tail_y;

    int checks = 0;
    int errors = 0;

    snake_body_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .segments  (segments),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .error     (error),
        .tail_x    (tail_x),
        .tail_y    (tail_y)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] obs();
        return {out_valid, out_x, out_y, out_idx, out_last};
    endfunction

    function automatic logic [17:0] coord(input logic [5:0] x, input logic [5:0] y,
                                          input logic [3:0] idx, input logic last);
        return {1'b1, x, y, idx, last};
    endfunction

    function automatic logic [32:0] all_outs();
        return {busy, out_valid, out_x, out_y, out_idx, out_last, done, error, tail_x, tail_y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns 1 time unit after the edge that accepted it.
    task automatic launch(input logic [5:0] hx, input logic [5:0] hy,
                          input logic [3:0] len, input logic [41:0] seg);
        head_x   = hx;
        head_y   = hy;
        length   = len;
        segments = seg;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (all_outs() !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (all_outs() !== 33'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        launch(6'd62, 6'd44, 4'd3, 42'(9'o033));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs() !== coord(6'd62, 6'(44 + i), 4'(i), i == 2) || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_emit[%0d]: got %h busy %b expected %h busy 1",
                         i, obs(), busy, coord(6'd62, 6'(44 + i), 4'(i), i == 2));
            end
            step();
        end
        checks++;
        if ({done, busy, out_valid, tail_x, tail_y} !== {3'b100, 6'd62, 6'd46}) begin
            errors++;
            $display("FAIL basic_done: got done %b busy %b valid %b tail (%0d,%0d) expected 1 0 0 (62,46)",
                     done, busy, out_valid, tail_x, tail_y);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse_width: got %b expected 0", done);
        end
    endtask

    task automatic test_wrap();
        logic [5:0]  hx [2];
        logic [5:0]  hy [2];
        logic [41:0] sg [2];
        logic [5:0]  ex [2][3];
        logic [5:0]  ey [2][3];
        hx = '{6'd63, 6'd0};
        hy = '{6'd0, 6'd47};
        sg = '{42'(6'o12), 42'(6'o43)};               // RIGHT,UP and DOWN,LEFT
        ex = '{'{6'd63, 6'd0, 6'd0}, '{6'd0, 6'd0, 6'd63}};
        ey = '{'{6'd0, 6'd0, 6'd47}, '{6'd47, 6'd0, 6'd0}};
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            launch(hx[c], hy[c], 4'd3, sg[c]);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs() !== coord(ex[c][i], ey[c][i], 4'(i), i == 2)) begin
                    errors++;
                    $display("FAIL wrap_emit[%0d][%0d]: got %h expected %h",
                             c, i, obs(), coord(ex[c][i], ey[c][i], 4'(i), i == 2));
                end
                step();
            end
            checks++;
            if ({done, tail_x, tail_y} !== {1'b1, ex[c][2], ey[c][2]}) begin
                errors++;
                $display("FAIL wrap_tail[%0d]: got done %b tail (%0d,%0d) expected 1 (%0d,%0d)",
                         c, done, tail_x, tail_y, ex[c][2], ey[c][2]);
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic       rdy [5];
        logic [3:0] eidx [5];
        int         hs;
        rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        eidx = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        hs   = 0;
        out_ready = 1'b0;
        launch(6'd62, 6'd44, 4'd3, 42'(9'o033));
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs() !== coord(6'd62, 6'd44 + 6'(eidx[i]), eidx[i], eidx[i] == 4'd2) || done !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h done %b expected %h done 0",
                         i, obs(), done, coord(6'd62, 6'd44 + 6'(eidx[i]), eidx[i], eidx[i] == 4'd2));
            end
            out_ready = rdy[i];
            #1;
            if (out_valid && out_ready) hs++;
            step();
        end
        checks++;
        if (hs !== 3 || done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_handshakes: got %0d handshakes done %b valid %b expected 3 1 0",
                     hs, done, out_valid);
        end
        step();
    endtask

    task automatic test_zero_length();
        out_ready = 1'b1;
        launch(6'd7, 6'd7, 4'd0, 42'(6'o22));
        checks++;
        if ({out_valid, busy, done, tail_x, tail_y} !== {3'b001, 6'd62, 6'd46}) begin
            errors++;
            $display("FAIL zero_len_done: got valid %b busy %b done %b tail (%0d,%0d) expected 0 0 1 (62,46)",
                     out_valid, busy, done, tail_x, tail_y);
        end
        step();
        checks++;
        if ({out_valid, done} !== 2'b00) begin
            errors++;
            $display("FAIL zero_len_idle: got valid %b done %b expected 0 0", out_valid, done);
        end
    endtask

    task automatic test_ignore_start();
        out_ready = 1'b0;
        launch(6'd10, 6'd20, 4'd3, 42'(9'o033));
        head_x   = 6'd1;
        head_y   = 6'd1;
        length   = 4'd1;
        segments = '0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        checks++;
        if (obs() !== coord(6'd10, 6'd20, 4'd0, 1'b0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start_hold: got %h busy %b expected %h busy 1",
                     obs(), busy, coord(6'd10, 6'd20, 4'd0, 1'b0));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs() !== coord(6'd10, 6'(20 + i), 4'(i), i == 2)) begin
                errors++;
                $display("FAIL ignore_start_emit[%0d]: got %h expected %h",
                         i, obs(), coord(6'd10, 6'(20 + i), 4'(i), i == 2));
            end
            step();
        end
        checks++;
        if ({done, tail_x, tail_y} !== {1'b1, 6'd10, 6'd22}) begin
            errors++;
            $display("FAIL ignore_start_tail: got done %b tail (%0d,%0d) expected 1 (10,22)",
                     done, tail_x, tail_y);
        end
        step();
    endtask

    task automatic test_error();
        logic [2:0] bad [4];
        bad = '{3'd6, 3'd0, 3'd5, 3'd7};
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            launch(6'd5, 6'd5, 4'd3, 42'(bad[c]) | 42'(6'o30));
            checks++;
            if (obs() !== coord(6'd5, 6'd5, 4'd0, 1'b0)) begin
                errors++;
                $display("FAIL error_first[%0d]: got %h expected %h",
                         c, obs(), coord(6'd5, 6'd5, 4'd0, 1'b0));
            end
            step();
            checks++;
            if ({error, done, out_valid, busy, tail_x, tail_y} !== {4'b1000, 6'd10, 6'd22}) begin
                errors++;
                $display("FAIL error_pulse[%0d]: got err %b done %b valid %b busy %b tail (%0d,%0d) expected 1 0 0 0 (10,22)",
                         c, error, done, out_valid, busy, tail_x, tail_y);
            end
            step();
            checks++;
            if ({error, out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL error_clear[%0d]: got err %b valid %b expected 0 0", c, error, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [41:0] left_chain;
        left_chain = '0;
        for (int k = 0; k < 14; k++) left_chain[3*k +: 3] = 3'd4;
        out_ready = 1'b1;
        launch(6'd2, 6'd10, 4'd15, left_chain);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs() !== coord(6'(2 - i), 6'd10, 4'(i), 1'b0)) begin
                errors++;
                $display("FAIL midreset_emit[%0d]: got %h expected %h",
                         i, obs(), coord(6'(2 - i), 6'd10, 4'(i), 1'b0));
            end
            step();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 33'd0) begin
            errors++;
            $display("FAIL midreset_async: got %h expected 0", all_outs());
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (all_outs() !== 33'd0) begin
            errors++;
            $display("FAIL midreset_no_pulse: got %h expected 0", all_outs());
        end
        launch(6'd2, 6'd10, 4'd15, left_chain);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (obs() !== coord(6'(2 - i), 6'd10, 4'(i), i == 14)) begin
                errors++;
                $display("FAIL restart_emit[%0d]: got %h expected %h",
                         i, obs(), coord(6'(2 - i), 6'd10, 4'(i), i == 14));
            end
            step();
        end
        checks++;
        if ({done, tail_x, tail_y} !== {1'b1, 6'd52, 6'd10}) begin
            errors++;
            $display("FAIL restart_tail: got done %b tail (%0d,%0d) expected 1 (52,10)",
                     done, tail_x, tail_y);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_length();
        test_ignore_start();
        test_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_body_decoder.md
Name: snake_body_decoder

Overview:
- Decodes a snake's direction-chained body into per-segment map coordinates.
- A snake is stored as the head position plus a list of step directions. This block walks that chain from the head toward the tail and emits one (x, y) tile coordinate per segment over a valid/ready stream.
- Consumers are the map-tile writer and the collision checker. It also reports the computed tail position for cross-checking against the stored tail.

Parameters:
- MAX_SNAKE_LENGTH, 15, maximum number of segments including the head.
- LENGTH_BITS, 4, width of the length field.
- MAP_WIDTH, 64, map columns; x wraps modulo this value.
- WIDTH_BITS, 6, width of the x coordinate.
- MAP_HEIGHT, 48, map rows; y wraps modulo this value.
- HEIGHT_BITS, 6, width of the y coordinate.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to decode the current snake inputs.
- head_x  in  WIDTH_BITS  head column.
- head_y  in  HEIGHT_BITS  head row.
- length  in  LENGTH_BITS  number of segments including the head.
- segments  in  3*(MAX_SNAKE_LENGTH-1)  packed directions. Entry i occupies bits [3i+2:3i] and is the step from segment i to segment i+1.
- busy  out  1  high from accepted start until done or error.
- out_valid  out  1  coordinate available.
- out_ready  in  1  consumer accepts the coordinate.
- out_x  out  WIDTH_BITS  segment column.
- out_y  out  HEIGHT_BITS  segment row.
- out_idx  out  LENGTH_BITS  segment index, 0 = head.
- out_last  out  1  current coordinate is the tail.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on an illegal direction.
- tail_x  out  WIDTH_BITS  tail column, updated on done.
- tail_y  out  HEIGHT_BITS  tail row, updated on done.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n is low, every output is 0 and the FSM is in IDLE.
- Direction encoding: 0 NONE, 1 UP (y-1), 2 RIGHT (x+1), 3 DOWN (y+1), 4 LEFT (x-1). Codes 5, 6 and 7 are illegal.
- Wrap rules:
  - x: 0-1 -> MAP_WIDTH-1; MAP_WIDTH-1+1 -> 0.
  - y: 0-1 -> MAP_HEIGHT-1; MAP_HEIGHT-1+1 -> 0.
  - No intermediate value ever exceeds the map bounds.
- FSM states: IDLE, EMIT, DONE, ERR.
- IDLE:
  - start=1 latches head_x, head_y, length and segments.
  - length is clamped to MAX_SNAKE_LENGTH.
  - If length=0, go to DONE and emit nothing; tail_x/tail_y are left unchanged.
  - Otherwise go to EMIT with idx=0 and coordinate = head.
  - busy rises the cycle after start; out_valid rises the same cycle (1-cycle latency).
- EMIT:
  - out_valid=1; out_x, out_y, out_idx and out_last stay stable until out_valid & out_ready.
  - out_last = (idx == length-1).
  - On a handshake with out_last=1: latch tail_x/tail_y from the emitted coordinate and go to DONE.
  - On a handshake otherwise: decode segments[idx].
    - Legal non-NONE code: step the coordinate, idx+1, and stay in EMIT. This gives one coordinate per cycle under continuous ready.
    - NONE or illegal code: go to ERR; out_valid drops the next cycle.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- ERR: error=1 and busy=0 for one cycle, then IDLE. tail_x/tail_y are not updated.
- Input handling:
  - start while busy is ignored.
  - Input changes after latching have no effect on the decode in progress.
- Reset mid-operation: rst_n low aborts immediately; no done or error pulse is generated.
- Self-crossing chains are not checked; they are emitted as-is.

Test Plan:
- head (62,44), length 3, segments [DOWN, DOWN], out_ready=1 -> emits (62,44,idx0), (62,45,idx1), (62,46,idx2,last) on consecutive cycles; done pulse; tail=(62,46).
- head (63,0), length 3, segments [RIGHT, UP] -> emits (63,0), (0,0), (0,47); tail=(0,47).
- Same as the first scenario with out_ready toggling 1,0,0,1,1 -> each coordinate stays stable while stalled; exactly 3 handshakes; done occurs after the 3rd handshake.
- length 0, start -> no out_valid; done pulse 1 cycle later; tail unchanged. A second start during busy in any case is ignored.
- head (5,5), length 3, segments[0]=6 -> emits (5,5,idx0); after that handshake an error pulse, no further valid, busy=0, tail unchanged.
- length 15 all LEFT from (2,10), rst_n pulled low after the 4th handshake -> all outputs 0 asynchronously; no done; a new start after release decodes correctly from idx 0.
